// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2^N one-hot decoder with an active-low enable
// and an auto-scan sequencer that walks a one-hot select from a start code to
// an end code (inclusive, wrapping), holding each code for HOLD cycles.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   en     : active-low enable; 1 blanks dec (and pauses a scan)
//   mode   : 0 = direct decode, 1 = scan (looked at only in IDLE)
//   start  : scan request (IDLE, mode=1, en=0)
//   enc    : direct code, or scan start code when start is taken
//   last   : scan end code, captured with start
//   dec    : registered one-hot select or all zeros
//   cur    : registered current code
//   busy   : high while scanning
//   done   : one-cycle pulse after the final code of a scan
//
// State | meaning
// IDLE  | direct decode / blank; waits for a scan request
// SCAN  | walking codes cur..last_q, hc counts hold cycles of the shown code
module decoder_seq #(
  parameter int N    = 4,
  parameter int M    = 2**N,
  parameter int HOLD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic         start,
  input  logic [N-1:0] enc,
  input  logic [N-1:0] last,
  output logic [M-1:0] dec,
  output logic [N-1:0] cur,
  output logic         busy,
  output logic         done
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HC_LAST = HW'(HOLD - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [HW-1:0] hc;
  logic [N-1:0]  last_q;

  function automatic logic [M-1:0] onehot(input logic [N-1:0] code);
    logic [M-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dec    <= '0;
      cur    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hc     <= '0;
      last_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            dec <= '0;
          end else if (!mode) begin
            dec <= onehot(enc);
            cur <= enc;
          end else if (start) begin
            dec    <= onehot(enc);
            cur    <= enc;
            last_q <= last;
            hc     <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end else begin
            dec <= '0;
          end
        end
        SCAN: begin
          if (en) begin
            // pause: blank the output, keep position and hold count
            dec <= '0;
          end else if (dec == '0) begin
            // resume: the re-show edge does not count toward the hold
            dec <= onehot(cur);
          end else if (hc != HC_LAST) begin
            hc <= hc + 1'b1;
          end else if (cur != last_q) begin
            // N-bit add wraps M-1 to 0 since M == 2**N
            cur <= cur + 1'b1;
            dec <= onehot(cur + 1'b1);
            hc  <= '0;
          end else begin
            dec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            hc    <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
module tb_decoder_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en, mode, start;
  logic [3:0]  enc, last;

  logic [15:0] dec_h1, dec_h3;
  logic [3:0]  cur_h1, cur_h3;
  logic        busy_h1, busy_h3, done_h1, done_h3;

  always #5 clk = ~clk;

  decoder_seq #(.N(4), .M(16), .HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
    .enc(enc), .last(last), .dec(dec_h1), .cur(cur_h1), .busy(busy_h1), .done(done_h1)
  );

  decoder_seq #(.N(4), .M(16), .HOLD(3)) u_h3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
    .enc(enc), .last(last), .dec(dec_h3), .cur(cur_h3), .busy(busy_h3), .done(done_h3)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0][15:0] dec;
    logic [1:0][3:0]  cur;
    logic [1:0]       busy;
    logic [1:0]       done;
  } exp_t;

  exp_t expq[$];

  // Reference model: a scan is "codes still to show after this one" plus
  // "active cycles left for the shown code".
  int          holdv[2] = '{1, 3};
  bit          m_scan[2];
  int          m_rem[2];
  int          m_left[2];
  logic [3:0]  m_cur[2];
  logic [15:0] m_dec[2];
  bit          m_busy[2];
  bit          m_done[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_scan[k] = 0; m_rem[k] = 0; m_left[k] = 0;
      m_cur[k] = '0; m_dec[k] = '0; m_busy[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    m_done[k] = 0;
    if (!m_scan[k]) begin
      if (en) m_dec[k] = '0;
      else if (!mode) begin
        m_cur[k] = enc;
        m_dec[k] = 16'd1 << enc;
      end else if (start) begin
        m_cur[k]  = enc;
        m_dec[k]  = 16'd1 << enc;
        m_rem[k]  = holdv[k];
        m_left[k] = (int'(last) - int'(enc) + 16) % 16;
        m_scan[k] = 1;
        m_busy[k] = 1;
      end else m_dec[k] = '0;
    end else begin
      if (en) m_dec[k] = '0;
      else if (m_dec[k] == '0) m_dec[k] = 16'd1 << m_cur[k];
      else begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          if (m_left[k] == 0) begin
            m_dec[k] = '0; m_busy[k] = 0; m_done[k] = 1; m_scan[k] = 0;
          end else begin
            m_left[k]--;
            m_cur[k] = 4'((int'(m_cur[k]) + 1) % 16);
            m_dec[k] = 16'd1 << m_cur[k];
            m_rem[k] = holdv[k];
          end
        end
      end
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.dec[k] = m_dec[k]; e.cur[k] = m_cur[k];
      e.busy[k] = m_busy[k]; e.done[k] = m_done[k];
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      expq.delete();
      expq.push_back('0);
    end else begin
      model_step(0);
      model_step(1);
      expq.push_back(snapshot());
    end
  end

  task automatic chk(input string name, input int hold, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s hold=%0d got=%0h expected=%0h at %0t", name, hold, act, exp, $time);
    end
  endtask

  logic [1:0][15:0] act_dec;
  logic [1:0][3:0]  act_cur;
  logic [1:0]       act_busy, act_done;
  assign act_dec  = {dec_h3, dec_h1};
  assign act_cur  = {cur_h3, cur_h1};
  assign act_busy = {busy_h3, busy_h1};
  assign act_done = {done_h3, done_h1};

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      for (int k = 0; k < 2; k++) begin
        chk("dec",  holdv[k], 32'(act_dec[k]),  32'(e.dec[k]));
        chk("cur",  holdv[k], 32'(act_cur[k]),  32'(e.cur[k]));
        chk("busy", holdv[k], 32'(act_busy[k]), 32'(e.busy[k]));
        chk("done", holdv[k], 32'(act_done[k]), 32'(e.done[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero_now(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_dec"},  holdv[k], 32'(act_dec[k]),  32'h0);
      chk({tag, "_cur"},  holdv[k], 32'(act_cur[k]),  32'h0);
      chk({tag, "_busy"}, holdv[k], 32'(act_busy[k]), 32'h0);
      chk({tag, "_done"}, holdv[k], 32'(act_done[k]), 32'h0);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired at %0t", name, $time);
  endtask

  initial begin
    int i;
    en = 1'b0; mode = 1'b0; start = 1'b0; enc = 4'd9; last = 4'd0;
    rst_n = 1'b0;
    #1;
    chk_zero_now("reset");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    step();

    // direct decode
    enc = 4'd5; step();
    en = 1'b1; step();
    en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      enc = 4'(c);
      step();
    end

    // wrapping scan 14..1
    mode = 1'b1; enc = 4'd14; last = 4'd1; start = 1'b1; step();
    start = 1'b0; enc = 4'($urandom); last = 4'($urandom);
    repeat (16) step();

    // single code, then back-to-back start in the done cycle of the HOLD=3 unit
    enc = 4'd3; last = 4'd3; start = 1'b1; step();
    start = 1'b0;
    i = 0;
    while (i < 20 && !m_done[1]) begin step(); i++; end
    if (!m_done[1]) bound_fail("single_done");
    enc = 4'd0; last = 4'd0; start = 1'b1; step();
    start = 1'b0;
    repeat (10) step();

    // pause while code 1 is shown on the HOLD=1 unit; start pulses ignored
    enc = 4'd0; last = 4'd3; start = 1'b1; step();
    start = 1'b0;
    i = 0;
    while (i < 20 && !(m_scan[0] && m_cur[0] == 4'd1 && m_dec[0] != 0)) begin step(); i++; end
    if (!(m_scan[0] && m_cur[0] == 4'd1)) bound_fail("pause_point");
    en = 1'b1; start = 1'b1; enc = 4'd9; step(); step();
    en = 1'b0;
    repeat (16) begin
      start = 1'($urandom_range(0, 1)); enc = 4'($urandom); last = 4'($urandom);
      step();
    end
    start = 1'b0;
    repeat (4) step();

    // async reset mid-scan
    enc = 4'd0; last = 4'd7; start = 1'b1; step();
    start = 1'b0;
    i = 0;
    while (i < 20 && !(m_scan[0] && m_cur[0] == 4'd2 && m_dec[0] != 0)) begin step(); i++; end
    if (!(m_scan[0] && m_cur[0] == 4'd2)) bound_fail("reset_point");
    rst_n = 1'b0;
    #1;
    chk_zero_now("async_rst");
    step(); step();
    rst_n = 1'b1;
    repeat (6) step();

    // randomized traffic
    repeat (400) begin
      en    = ($urandom_range(0, 4) == 0);
      mode  = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 2) == 0);
      enc   = 4'($urandom);
      last  = 4'($urandom);
      step();
    end
    en = 1'b0; mode = 1'b0; start = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Parametrised, registered N-to-2^N one-hot decoder with an active-low enable and an auto-scan sequencer. In direct mode it decodes `enc` to a registered one-hot `dec` each cycle. In scan mode it walks a one-hot select from a start code to an end code, with wrap-around, a programmable per-code hold time and pause-on-disable. It drives word-line/row/channel selects in the datapath where a fixed 4-to-16 combinational decode is not enough.

## Interface
- `N`, 4, code width in bits (≥1)
- `M`, 2**N, output width; must equal 2**N
- `HOLD`, 1, cycles each code is held in scan mode (≥1); counter width is clog2(HOLD), minimum 1 bit
- `clk` in 1: single clock; all state updates on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `en` in 1: active-low enable; 1 forces `dec` to zero at the next edge
- `mode` in 1: 0 = direct decode, 1 = scan; sampled only in IDLE
- `start` in 1: single-cycle scan request; sampled only in IDLE with `mode`=1 and `en`=0
- `enc` in N: direct-mode code, or scan start code when `start` is sampled
- `last` in N: scan end code (inclusive); sampled with `start` and held internally
- `dec` out M: registered one-hot select, or all zeros
- `cur` out N: registered current code
- `busy` out 1: high while in SCAN
- `done` out 1: one-cycle pulse when a scan completes

## Operation
- Reset (async assert): `dec`=0, `cur`=0, `busy`=0, `done`=0, hold counter `hc`=0, state IDLE, latched end code=0.
- States: IDLE, SCAN.
- IDLE, `en`=1: `dec`<=0; `cur` holds; `start` ignored.
- IDLE, `en`=0, `mode`=0: `dec`<=onehot(`enc`), `cur`<=`enc`. `start` ignored.
- IDLE, `en`=0, `mode`=1, `start`=0: `dec`<=0, `cur` holds.
- IDLE, `en`=0, `mode`=1, `start`=1: `cur`<=`enc`, `dec`<=onehot(`enc`), latch `last`, `hc`<=0, `busy`<=1. Go to SCAN.
- In SCAN, each edge is one of the following:
  - Pause edge (`en`=1): `dec`<=0. `cur` and `hc` freeze.
  - Resume edge (`en`=0 and `dec`==0): `dec`<=onehot(`cur`). `hc` does not advance.
  - Active edge (`en`=0 and `dec`!=0):
    - `hc`<HOLD-1: `hc`<=`hc`+1.
    - `hc`==HOLD-1 and `cur`!=latched last: `cur`<=(`cur`+1) mod M (wrap from M-1 to 0), `dec`<=onehot(new `cur`), `hc`<=0.
    - `hc`==HOLD-1 and `cur`==latched last: `dec`<=0, `busy`<=0, `done`<=1, `hc`<=0. Go to IDLE.
- `done` is high for exactly one cycle; it is cleared on every edge except the completion edge.
- `start`, `mode`, `enc`, `last` are ignored during SCAN.
- Codes visited per scan = ((last − start) mod M) + 1. start==last gives a single code; a wrapping range covers e.g. 14,15,0,1.
- Invariant: `dec` is all zeros or exactly one-hot. `dec`!=0 in SCAN implies `dec`==onehot(`cur`).

## Timing
- Direct decode latency: 1 cycle (`enc` at edge t, `dec` valid after t).
- Scan: first code visible in the cycle after the `start` edge. Each unpaused code is visible for exactly HOLD cycles.
- Completion: `dec`=0, `busy`=0, `done`=1 in the cycle after the last code's final hold cycle.
- Pause: `dec`=0 from the cycle after `en` rises. The code returns in the cycle after `en` falls and is then held for the remainder of its HOLD (`hc` is preserved).
- New scan: a `start` in the cycle `done`=1 (IDLE) is accepted, giving back-to-back scans with one zero cycle between them.
- Reset mid-scan: all outputs go to 0 immediately, without waiting for a clock edge. After release the block is in IDLE and a new `start` is required.

## Test plan
- Reset: hold `rst_n`=0 with `en`=0, `mode`=0, `enc`=9 -> `dec`=0x0000, `cur`=0, `busy`=0, `done`=0. Release -> `dec`=0x0200 one edge later.
- Direct decode (N=4): `en`=0, `mode`=0, `enc`=5 -> `dec`=0x0020 after 1 edge. `en`=1 -> `dec`=0x0000 next edge. Sweep all 16 codes and check one-hot.
- Wrapping scan (HOLD=1): `start` with `enc`=14, `last`=1 -> `dec` = 0x4000, 0x8000, 0x0001, 0x0002 on consecutive cycles, then `dec`=0 with `done`=1 for one cycle; `busy` high for exactly 4 cycles.
- Hold and single code (HOLD=2): `start` with `enc`=3, `last`=3 -> `dec`=0x0008 for 2 cycles, then `done` pulse. A `start` in the `done` cycle with `enc`=0, `last`=0 -> `dec`=0x0001 for 2 cycles.
- Pause (HOLD=1): scan `enc`=0, `last`=3. Drive `en`=1 for 2 cycles while `dec`=0x0002 -> `dec`=0 for 2 cycles, then 0x0002, 0x0004, 0x0008, then `done`. `start` pulses during the scan have no effect.
- Async reset mid-scan: assert `rst_n` low between edges while `dec`=0x0004 -> `dec`=0, `busy`=0 immediately. After release, no `dec` activity until a new `start`.
